// File: rtl/mips_pkg.sv
// mips_pkg
// Shared MIPS datapath definitions: R-type funct codes for the ALU and the
// multiply/divide unit, the MDU state and operation enums, and a small
// decode helper used by the MDU front end.
`timescale 1ns/1ps
package mips_pkg;

  // ALU R-type funct codes
  localparam logic [5:0] FUNCT_ADD   = 6'b100000;
  localparam logic [5:0] FUNCT_ADDU  = 6'b100001;
  localparam logic [5:0] FUNCT_SUB   = 6'b100010;
  localparam logic [5:0] FUNCT_SUBU  = 6'b100011;
  localparam logic [5:0] FUNCT_AND   = 6'b100100;
  localparam logic [5:0] FUNCT_OR    = 6'b100101;
  localparam logic [5:0] FUNCT_XOR   = 6'b100110;
  localparam logic [5:0] FUNCT_NOR   = 6'b100111;
  localparam logic [5:0] FUNCT_SLT   = 6'b101010;
  localparam logic [5:0] FUNCT_SLTU  = 6'b101011;

  // HI/LO move and multiply/divide funct codes
  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  typedef enum logic [1:0] {IDLE, RUN, FIX} mdu_state_t;
  typedef enum logic {OP_MUL, OP_DIV} mdu_op_t;

  // Signed requests are the ones whose operands need magnitude conversion
  // and whose results need sign correction afterwards.
  function automatic logic is_signed_funct(input logic [5:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_DIV);
  endfunction

endpackage

// File: rtl/mips_mdu_step.sv
// mips_mdu_step
// One iteration of the MDU datapath, purely combinational.
//   op         : OP_MUL = add-shift step, OP_DIV = restoring divide step
//   acc_hi     : upper accumulator / partial remainder (WIDTH+1 bits)
//   acc_lo     : multiplier bits (multiply) or dividend/quotient bits (divide)
//   opnd       : multiplicand or divisor magnitude
//   acc_hi_nxt, acc_lo_nxt : accumulator after this iteration
`timescale 1ns/1ps
module mips_mdu_step
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  mdu_op_t            op,
  input  logic [WIDTH:0]     acc_hi,
  input  logic [WIDTH-1:0]   acc_lo,
  input  logic [WIDTH-1:0]   opnd,
  output logic [WIDTH:0]     acc_hi_nxt,
  output logic [WIDTH-1:0]   acc_lo_nxt
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;

  // Multiply: add the multiplicand when the current multiplier LSB is set,
  // then shift the whole {sum, multiplier} pair right by one. Divide: shift
  // the next dividend bit into the remainder and keep the subtraction only
  // when it does not go negative; that decision is the new quotient bit.
  always_comb begin
    sum        = acc_hi + (acc_lo[0] ? {1'b0, opnd} : '0);
    shifted    = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    trial      = {1'b0, shifted} - {2'b00, opnd};
    acc_hi_nxt = acc_hi;
    acc_lo_nxt = acc_lo;
    if (op == OP_MUL) begin
      acc_hi_nxt = {1'b0, sum[WIDTH:1]};
      acc_lo_nxt = {sum[0], acc_lo[WIDTH-1:1]};
    end else begin
      acc_hi_nxt = trial[WIDTH+1] ? shifted : trial[WIDTH:0];
      acc_lo_nxt = {acc_lo[WIDTH-2:0], ~trial[WIDTH+1]};
    end
  end

endmodule

// File: rtl/mips_mdu.sv
// mips_mdu
// Iterative multiply/divide unit owning the HI/LO register pair.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   start/func : request and its R-type funct (sampled only when idle)
//   a, b       : rs / rt operands
//   busy       : an iterative op is in flight (RUN or FIX)
//   done, div0 : one-cycle pulses when a mult/div finishes (div0 = b was 0)
//   hi, lo     : HI and LO registers
`timescale 1ns/1ps
module mips_mdu
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       func,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  mdu_state_t         state_q, state_d;
  mdu_op_t            op_q, op_d;
  logic               neg_quo_q, neg_quo_d;
  logic               neg_rem_q, neg_rem_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic [WIDTH:0]     acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               div0_q, div0_d;

  logic               signed_req;
  logic               is_div_req;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     step_hi;
  logic [WIDTH-1:0]   step_lo;
  logic [2*WIDTH-1:0] prod, prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // The iterations run on unsigned magnitudes; signs are reapplied in FIX.
  assign signed_req = is_signed_funct(func);
  assign is_div_req = (func == FUNCT_DIV) || (func == FUNCT_DIVU);
  assign a_mag      = (signed_req && a[WIDTH-1]) ? -a : a;
  assign b_mag      = (signed_req && b[WIDTH-1]) ? -b : b;

  assign prod     = {acc_hi_q[WIDTH-1:0], acc_lo_q};
  assign prod_fix = neg_quo_q ? -prod : prod;
  assign quo_fix  = neg_quo_q ? -acc_lo_q : acc_lo_q;
  assign rem_fix  = neg_rem_q ? -acc_hi_q[WIDTH-1:0] : acc_hi_q[WIDTH-1:0];

  mips_mdu_step #(.WIDTH(WIDTH)) u_step (
    .op         (op_q),
    .acc_hi     (acc_hi_q),
    .acc_lo     (acc_lo_q),
    .opnd       (opnd_q),
    .acc_hi_nxt (step_hi),
    .acc_lo_nxt (step_lo)
  );

  // Next-state logic. For a multiply the multiplier (b) sits in the low
  // accumulator half and a is added in; for a divide the dividend (a) is
  // shifted out of the low half while quotient bits shift in behind it.
  // Divide by zero still runs all iterations but leaves HI/LO untouched.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    count_d   = count_q;
    opnd_d    = opnd_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    div0_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (func)
            FUNCT_MTHI: hi_d = a;
            FUNCT_MTLO: lo_d = a;
            FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU: begin
              op_d      = is_div_req ? OP_DIV : OP_MUL;
              neg_quo_d = signed_req & (a[WIDTH-1] ^ b[WIDTH-1]);
              neg_rem_d = (func == FUNCT_DIV) & a[WIDTH-1];
              count_d   = CNT_W'(WIDTH - 1);
              acc_hi_d  = '0;
              acc_lo_d  = is_div_req ? a_mag : b_mag;
              opnd_d    = is_div_req ? b_mag : a_mag;
              state_d   = RUN;
            end
            default: ;
          endcase
        end
      end
      RUN: begin
        acc_hi_d = step_hi;
        acc_lo_d = step_lo;
        count_d  = count_q - CNT_W'(1);
        if (count_q == '0) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (op_q == OP_MUL) begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end else if (opnd_q == '0) begin
          div0_d = 1'b1;
        end else begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any op in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= OP_MUL;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      count_q   <= '0;
      opnd_q    <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      count_q   <= count_d;
      opnd_q    <= opnd_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      div0_q    <= div0_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign div0 = div0_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mips_mdu.sv
`timescale 1ns/1ps
module tb_mips_mdu;
  import mips_pkg::*;

  typedef struct {
    logic [63:0] hi;
    logic [63:0] lo;
    logic        div0;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic [5:0]  func = '0;
  logic [31:0] a = '0, b = '0;
  logic        busy, done, div0;
  logic [31:0] hi, lo;

  logic        start8 = 1'b0;
  logic [5:0]  func8 = '0;
  logic [7:0]  a8 = '0, b8 = '0;
  logic        busy8, done8, div08;
  logic [7:0]  hi8, lo8;

  int compared = 0;
  int mismatched = 0;

  exp_t sb[$];
  exp_t sb8[$];
  logic [31:0] model_hi = '0, model_lo = '0;
  logic [7:0]  model8_hi = '0, model8_lo = '0;

  logic [5:0] funcs [6] = '{FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_MTHI, FUNCT_MTLO};

  always #5 clk = ~clk;

  mips_mdu #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .func(func), .a(a), .b(b),
    .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
  );

  mips_mdu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .func(func8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .div0(div08), .hi(hi8), .lo(lo8)
  );

  // Single comparison point: every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model at w bits: plain signed/unsigned arithmetic on
  // sign-extended integers, truncated back to w bits.
  function automatic exp_t refModel(input int w, input logic [5:0] f, input logic [63:0] av,
                                    input logic [63:0] bv, input logic [63:0] hp, input logic [63:0] lp);
    exp_t r;
    logic [63:0] mask, ua, ub, p, q, m;
    longint sa, sb_;
    mask = (64'd1 << w) - 64'd1;
    ua = av & mask;
    ub = bv & mask;
    sa  = ua[w-1] ? longint'(ua) - longint'(64'd1 << w) : longint'(ua);
    sb_ = ub[w-1] ? longint'(ub) - longint'(64'd1 << w) : longint'(ub);
    r.hi = hp; r.lo = lp; r.div0 = 1'b0;
    p = '0; q = '0; m = '0;
    case (f)
      FUNCT_MULT:  begin p = sa * sb_; r.hi = (p >> w) & mask; r.lo = p & mask; end
      FUNCT_MULTU: begin p = ua * ub;  r.hi = (p >> w) & mask; r.lo = p & mask; end
      FUNCT_DIV, FUNCT_DIVU: begin
        if (ub == 64'd0) r.div0 = 1'b1;
        else begin
          if (f == FUNCT_DIV) begin q = sa / sb_; m = sa % sb_; end
          else begin q = ua / ub; m = ua % ub; end
          r.hi = m & mask;
          r.lo = q & mask;
        end
      end
      default: ;
    endcase
    return r;
  endfunction

  // Monitor for the 32-bit unit: each done pulse retires one scoreboard entry.
  always @(negedge clk) begin
    if (rst_n && done) begin
      if (sb.size() == 0) checkOutput("unexpected_done", 64'(done), 64'd0);
      else begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("hi", 64'(hi), e.hi);
        checkOutput("lo", 64'(lo), e.lo);
        checkOutput("div0", 64'(div0), 64'(e.div0));
      end
    end else if (div0) checkOutput("div0_without_done", 64'(div0), 64'd0);
  end

  // Monitor for the 8-bit unit.
  always @(negedge clk) begin
    if (rst_n && done8) begin
      if (sb8.size() == 0) checkOutput("unexpected_done8", 64'(done8), 64'd0);
      else begin
        exp_t e;
        e = sb8.pop_front();
        checkOutput("hi8", 64'(hi8), e.hi);
        checkOutput("lo8", 64'(lo8), e.lo);
        checkOutput("div08", 64'(div08), 64'(e.div0));
      end
    end
  end

  // Issue one request to the 32-bit unit and, for mult/div, follow it to
  // done. Optionally pokes an ignored divu while busy or pulls reset mid-run.
  task automatic applyStimulus(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv,
                               input int poke_cycle = 0, input int reset_cycle = 0);
    int cyc, busy_cnt;
    logic iter;
    logic [31:0] old_hi;
    exp_t e;
    @(negedge clk);
    start = 1'b1; func = f; a = av; b = bv;
    old_hi = model_hi;
    iter = f inside {FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU};
    if (iter) begin
      e = refModel(32, f, 64'(av), 64'(bv), 64'(model_hi), 64'(model_lo));
      sb.push_back(e);
      model_hi = e.hi[31:0];
      model_lo = e.lo[31:0];
    end else if (f == FUNCT_MTHI) model_hi = av;
    else if (f == FUNCT_MTLO) model_lo = av;
    @(posedge clk);
    #1 start = 1'b0;
    if (!iter) begin
      checkOutput("hi_after_issue", 64'(hi), 64'(model_hi));
      checkOutput("lo_after_issue", 64'(lo), 64'(model_lo));
      checkOutput("busy_after_nonmdu", 64'(busy), 64'd0);
      return;
    end
    checkOutput("busy_after_start", 64'(busy), 64'd1);
    cyc = 0;
    busy_cnt = 0;
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (cyc == poke_cycle) begin
        start = 1'b1; func = FUNCT_DIVU; a = $urandom; b = $urandom;
      end else start = 1'b0;
      if (cyc == reset_cycle) begin
        rst_n = 1'b0;
        #1;
        checkOutput("busy_in_reset", 64'(busy), 64'd0);
        checkOutput("hi_in_reset", 64'(hi), 64'd0);
        checkOutput("lo_in_reset", 64'(lo), 64'd0);
        checkOutput("done_in_reset", 64'(done), 64'd0);
        void'(sb.pop_back());
        model_hi = '0;
        model_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (cyc == 16) checkOutput("hi_stable_in_run", 64'(hi), 64'(old_hi));
      if (done) break;
      if (busy) busy_cnt++;
    end
    checkOutput("done_latency", 64'(cyc), 64'd34);
    checkOutput("busy_cycles", 64'(busy_cnt), 64'd33);
    checkOutput("busy_low_at_done", 64'(busy), 64'd0);
  endtask

  // Issue one mult/div to the 8-bit unit and wait for its done pulse.
  task automatic apply8(input logic [5:0] f, input logic [7:0] av, input logic [7:0] bv);
    int cyc;
    exp_t e;
    @(negedge clk);
    start8 = 1'b1; func8 = f; a8 = av; b8 = bv;
    e = refModel(8, f, 64'(av), 64'(bv), 64'(model8_hi), 64'(model8_lo));
    sb8.push_back(e);
    model8_hi = e.hi[7:0];
    model8_lo = e.lo[7:0];
    @(posedge clk);
    #1 start8 = 1'b0;
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done8) break;
    end
    checkOutput("done8_latency", 64'(cyc), 64'd10);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] av, bv;
    logic [5:0]  f;
    #2 rst_n = 1'b0;
    #1;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_div0", 64'(div0), 64'd0);
    checkOutput("reset_hi", 64'(hi), 64'd0);
    checkOutput("reset_lo", 64'(lo), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] directed operations");
    applyStimulus(FUNCT_MULT, 32'hFFFFFFFD, 32'd5);
    checkOutput("mult_m3x5_hi", 64'(hi), 64'hFFFFFFFF);
    checkOutput("mult_m3x5_lo", 64'(lo), 64'hFFFFFFF1);
    applyStimulus(FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
    applyStimulus(FUNCT_DIV, 32'hFFFFFFF9, 32'd2);
    checkOutput("div_m7_2_lo", 64'(lo), 64'hFFFFFFFD);
    checkOutput("div_m7_2_hi", 64'(hi), 64'hFFFFFFFF);
    applyStimulus(FUNCT_DIVU, 32'd7, 32'd2);
    applyStimulus(FUNCT_MTHI, 32'h12345678, 32'd0);
    applyStimulus(FUNCT_MTLO, 32'h9ABCDEF0, 32'd0);
    applyStimulus(FUNCT_DIVU, 32'd100, 32'd0);
    checkOutput("div0_keeps_hi", 64'(hi), 64'h12345678);
    applyStimulus(FUNCT_DIV, 32'h80000000, 32'hFFFFFFFF);
    applyStimulus(FUNCT_MULT, 32'd1234, 32'hFFFF0000, 5, 0);
    applyStimulus(FUNCT_MULT, 32'd77, 32'd99, 0, 10);
    applyStimulus(FUNCT_MULT, 32'hFFFFFFFF, 32'h7FFFFFFF);
    applyStimulus(FUNCT_ADD, 32'h55555555, 32'h1);
    repeat (3) @(negedge clk);
    checkOutput("add_no_busy", 64'(busy), 64'd0);

    $display("[TB] randomized operations");
    for (int i = 0; i < 40; i++) begin
      f  = funcs[$urandom_range(5)];
      av = $urandom;
      bv = ($urandom_range(7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(9) == 0) av = 32'h80000000;
      if ($urandom_range(9) == 0) bv = 32'hFFFFFFFF;
      applyStimulus(f, av, bv);
    end

    $display("[TB] 8-bit instance");
    apply8(FUNCT_MULT, 8'h80, 8'hFF);
    checkOutput("mult8_hi", 64'(hi8), 64'h00);
    checkOutput("mult8_lo", 64'(lo8), 64'h80);
    for (int i = 0; i < 16; i++) begin
      f = funcs[$urandom_range(3)];
      apply8(f, 8'($urandom), 8'($urandom_range(255)));
    end

    repeat (3) @(negedge clk);
    checkOutput("sb_drained", 64'(sb.size()), 64'd0);
    checkOutput("sb8_drained", 64'(sb8.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
